// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared defaults and helpers for the scoreboarded register file.
//   DATA_W_DEF / NREGS_DEF : default register width and register count
//   ZERO_REG               : index of the hard-wired zero register
//   port_lsb()             : LSB offset of port k inside a packed multi-port bus
package reg_file_sb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned NREGS_DEF  = 32;
  localparam int unsigned ZERO_REG   = 0;

  // Offset of slice 'port' in a bus packed as {port N-1, ..., port 0}
  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// rf_scoreboard: per-register pending bits for outstanding long-latency producers.
//   clk, rst           : clock, async active-high reset
//   we, wr_clr, wr_addr: writeback; we && wr_clr retires the producer of wr_addr
//   issue_valid/addr   : request to mark issue_addr pending
//   flush              : clear every pending bit (wins over a same-cycle issue)
//   issue_ready        : issue can be accepted this cycle
//   pending            : registered pending vector (bit 0 never set)
//   pending_cnt        : registered popcount of pending
module rf_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter  int unsigned NREGS  = NREGS_DEF,
  localparam int unsigned ADDR_W = $clog2(NREGS),
  localparam int unsigned CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              wr_clr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              flush,
  output logic              issue_ready,
  output logic [NREGS-1:0]  pending,
  output logic [CNT_W-1:0]  pending_cnt
);

  logic [NREGS-1:0] r_pending;
  logic [CNT_W-1:0] r_cnt;
  logic [NREGS-1:0] w_pending_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_clr_hit;
  logic             w_issue_fire;

  // A retiring writeback frees its register for a same-cycle re-issue
  assign w_clr_hit    = we && wr_clr && (wr_addr != ADDR_W'(ZERO_REG));
  assign issue_ready  = !r_pending[issue_addr] || (w_clr_hit && (wr_addr == issue_addr));
  assign w_issue_fire = issue_valid && issue_ready && (issue_addr != ADDR_W'(ZERO_REG));

  // Next pending vector: clear, then set (set wins), then flush overrides all
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_clr_hit)    w_pending_nxt[wr_addr]    = 1'b0;
    if (w_issue_fire) w_pending_nxt[issue_addr] = 1'b1;
    if (flush)        w_pending_nxt             = '0;
    w_pending_nxt[ZERO_REG] = 1'b0;
  end

  // Popcount of the next vector so the count tracks the bits on the same edge
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      w_cnt_nxt = w_cnt_nxt + CNT_W'(w_pending_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_cnt     <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign pending     = r_pending;
  assign pending_cnt = r_cnt;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: NREAD-read / 1-write register file with a RAW-hazard scoreboard.
//   clk, rst                  : clock, async active-high reset
//   rd_addr / rd_data         : packed read indices / combinational read data
//   rd_ready                  : per-port operand not pending
//   we, wr_addr, wr_data      : writeback port
//   wr_clr                    : writeback retires a scoreboarded producer
//   issue_valid/addr, issue_ready : mark a long-latency destination pending
//   flush                     : clear all pending bits
//   pending_cnt               : number of pending registers
// Optional macro RF_BYPASS_EN: forward same-cycle writeback data/ready to reads.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned NREGS  = NREGS_DEF,
  parameter  int unsigned NREAD  = 2,
  localparam int unsigned ADDR_W = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*DATA_W-1:0] rd_data,
  output logic [NREAD-1:0]        rd_ready,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    wr_clr,
  input  logic                    issue_valid,
  input  logic [ADDR_W-1:0]       issue_addr,
  output logic                    issue_ready,
  input  logic                    flush,
  output logic [ADDR_W:0]         pending_cnt
);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  w_pending;
  logic              w_wr_en;

  assign w_wr_en = we && (wr_addr != ADDR_W'(ZERO_REG));

  // Storage; register 0 is never written so it stays at its reset value of 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  rf_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk         (clk),
    .rst         (rst),
    .we          (we),
    .wr_clr      (wr_clr),
    .wr_addr     (wr_addr),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .flush       (flush),
    .issue_ready (issue_ready),
    .pending     (w_pending),
    .pending_cnt (pending_cnt)
  );

  // Per-port read mux and optional writeback bypass
  for (genvar k = 0; k < int'(NREAD); k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_rdy;

    assign w_addr = rd_addr[port_lsb(k, ADDR_W) +: ADDR_W];

    always_comb begin
      w_data = r_regs[w_addr];
      w_rdy  = !w_pending[w_addr];
`ifdef RF_BYPASS_EN
      if (w_wr_en && (wr_addr == w_addr)) begin
        w_data = wr_data;
        if (wr_clr) w_rdy = 1'b1;
      end
`endif
    end

    assign rd_data[port_lsb(k, DATA_W) +: DATA_W] = w_data;
    assign rd_ready[k]                            = w_rdy;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed self-checking bench for reg_file_sb (default parameters).
module tb_reg_file_sb;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned NREAD  = 2;
  localparam int unsigned ADDR_W = 5;

  logic                    clk;
  logic                    rst;
  logic [NREAD*ADDR_W-1:0] rd_addr;
  logic [NREAD*DATA_W-1:0] rd_data;
  logic [NREAD-1:0]        rd_ready;
  logic                    we;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    wr_clr;
  logic                    issue_valid;
  logic [ADDR_W-1:0]       issue_addr;
  logic                    issue_ready;
  logic                    flush;
  logic [ADDR_W:0]         pending_cnt;

  int n_cmp;
  int n_bad;

  reg_file_sb #(.DATA_W(DATA_W), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .we          (we),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_clr      (wr_clr),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .issue_ready (issue_ready),
    .flush       (flush),
    .pending_cnt (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic drive_wr(input logic e, input logic c, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
    we = e; wr_clr = c; wr_addr = a; wr_data = d;
  endtask

  task automatic drive_iss(input logic v, input logic [ADDR_W-1:0] a);
    issue_valid = v; issue_addr = a;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    flush = 1'b0;
    set_rd(5'd0, 5'd0);
    drive_wr(1'b0, 1'b0, 5'd0, 32'h0);
    drive_iss(1'b0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data", 64'(rd_data), 64'h0);
    chk("reset_ready", 64'(rd_ready), 64'h3);
    chk("reset_issue_ready", 64'(issue_ready), 64'h1);
    chk("reset_cnt", 64'(pending_cnt), 64'h0);
    rst = 1'b0;
    tick();

    // Reset mid-operation discards data and outstanding producers
    drive_wr(1'b1, 1'b0, 5'd5, 32'h1234);
    drive_iss(1'b1, 5'd8);
    tick();
    drive_wr(1'b0, 1'b0, 5'd0, 32'h0);
    drive_iss(1'b0, 5'd0);
    set_rd(5'd5, 5'd8);
    #1;
    chk("pre_rst_r5", 64'(rd_data[31:0]), 64'h1234);
    chk("pre_rst_r8_ready", 64'(rd_ready[1]), 64'h0);
    chk("pre_rst_cnt", 64'(pending_cnt), 64'h1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_r5", 64'(rd_data[31:0]), 64'h0);
    chk("mid_rst_ready", 64'(rd_ready), 64'h3);
    chk("mid_rst_cnt", 64'(pending_cnt), 64'h0);
    #1 rst = 1'b0;
    tick();

    // Plain write/read, then write to r0 is ignored
    drive_wr(1'b1, 1'b0, 5'd3, 32'hDEADBEEF);
    tick();
    drive_wr(1'b1, 1'b0, 5'd0, 32'h0000FFFF);
    set_rd(5'd0, 5'd3);
    #1;
    chk("wr_r3_port1", 64'(rd_data[63:32]), 64'hDEADBEEF);
    chk("wr_r0_same_cycle", 64'(rd_data[31:0]), 64'h0);
    tick();
    drive_wr(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("wr_r0_after", 64'(rd_data[31:0]), 64'h0);
    chk("plain_wr_cnt", 64'(pending_cnt), 64'h0);

    // Issue to r0: accepted, no effect
    drive_iss(1'b1, 5'd0);
    #1;
    chk("issue_r0_ready", 64'(issue_ready), 64'h1);
    tick();
    drive_iss(1'b0, 5'd0);
    #1;
    chk("issue_r0_cnt", 64'(pending_cnt), 64'h0);
    chk("issue_r0_rd_ready", 64'(rd_ready[0]), 64'h1);

    // Scoreboard: issue r7, WAW stall, clearing writeback
    drive_iss(1'b1, 5'd7);
    #1;
    chk("issue_r7_ready", 64'(issue_ready), 64'h1);
    tick();
    set_rd(5'd7, 5'd3);
    #1;
    chk("r7_pending_ready", 64'(rd_ready), 64'h2);
    chk("r7_cnt", 64'(pending_cnt), 64'h1);
    chk("r7_waw_stall", 64'(issue_ready), 64'h0);
    tick();
    drive_iss(1'b0, 5'd7);
    #1;
    chk("r7_cnt_after_stall", 64'(pending_cnt), 64'h1);
    drive_wr(1'b1, 1'b1, 5'd7, 32'h55);
    #1;
    chk("r7_clr_frees_issue", 64'(issue_ready), 64'h1);
`ifdef RF_BYPASS_EN
    chk("bypass_data", 64'(rd_data[31:0]), 64'h55);
    chk("bypass_ready", 64'(rd_ready[0]), 64'h1);
`else
    chk("nobypass_data", 64'(rd_data[31:0]), 64'h0);
    chk("nobypass_ready", 64'(rd_ready[0]), 64'h0);
`endif
    tick();
    drive_wr(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("r7_cleared_ready", 64'(rd_ready[0]), 64'h1);
    chk("r7_data", 64'(rd_data[31:0]), 64'h55);
    chk("r7_cleared_cnt", 64'(pending_cnt), 64'h0);

    // wr_clr without we is ignored; we without wr_clr keeps pending
    drive_iss(1'b1, 5'd10);
    tick();
    drive_iss(1'b0, 5'd0);
    drive_wr(1'b0, 1'b1, 5'd10, 32'h99);
    set_rd(5'd10, 5'd10);
    tick();
    #1;
    chk("clr_no_we_cnt", 64'(pending_cnt), 64'h1);
    drive_wr(1'b1, 1'b0, 5'd10, 32'h99);
    tick();
    drive_wr(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("we_no_clr_ready", 64'(rd_ready), 64'h0);
    chk("we_no_clr_data", 64'(rd_data[31:0]), 64'h99);
    drive_wr(1'b1, 1'b1, 5'd10, 32'h99);
    tick();
    drive_wr(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("r10_cleared_cnt", 64'(pending_cnt), 64'h0);

    // Simultaneous clear and re-issue of r9: set wins
    drive_iss(1'b1, 5'd9);
    tick();
    drive_wr(1'b1, 1'b1, 5'd9, 32'hAA);
    #1;
    chk("sim_issue_ready", 64'(issue_ready), 64'h1);
    tick();
    drive_wr(1'b0, 1'b0, 5'd0, 32'h0);
    drive_iss(1'b0, 5'd0);
    set_rd(5'd3, 5'd9);
    #1;
    chk("sim_r9_data", 64'(rd_data[63:32]), 64'hAA);
    chk("sim_r9_ready", 64'(rd_ready), 64'h1);
    chk("sim_cnt", 64'(pending_cnt), 64'h1);
    drive_wr(1'b1, 1'b1, 5'd9, 32'hAA);
    tick();
    drive_wr(1'b0, 1'b0, 5'd0, 32'h0);

    // Flush with a same-cycle issue: flush wins
    for (int r = 1; r <= 3; r++) begin
      drive_iss(1'b1, ADDR_W'(r));
      tick();
    end
    drive_iss(1'b0, 5'd0);
    #1;
    chk("pre_flush_cnt", 64'(pending_cnt), 64'h3);
    flush = 1'b1;
    drive_iss(1'b1, 5'd4);
    tick();
    flush = 1'b0;
    drive_iss(1'b0, 5'd0);
    set_rd(5'd4, 5'd1);
    #1;
    chk("flush_cnt", 64'(pending_cnt), 64'h0);
    chk("flush_ready", 64'(rd_ready), 64'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the core's register file: N read ports, one write port, plus a per-register scoreboard that tracks outstanding long-latency producers (loads, multi-cycle ops). It lets the next-generation multicycle/pipelined core stall on RAW hazards instead of relying on single-cycle memory. It sits between decode (issue/read side) and writeback (write side).

Parameters:
DATA_W, 32, register width in bits
NREGS, 32, number of architectural registers (power of 2, >=2)
NREAD, 2, number of read ports (1..4)
ADDR_W, $clog2(NREGS), register index width (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
rd_addr  in  NREAD*ADDR_W  packed read indices, port k at [k*ADDR_W +: ADDR_W]
rd_data  out  NREAD*DATA_W  packed read data, combinational from rd_addr
rd_ready  out  NREAD  port k operand not pending (valid to consume this cycle)
we  in  1  writeback enable
wr_addr  in  ADDR_W  writeback index
wr_data  in  DATA_W  writeback data
wr_clr  in  1  writeback retires a scoreboarded producer (clears pending)
issue_valid  in  1  request to mark issue_addr pending
issue_addr  in  ADDR_W  destination of the long-latency op being issued
issue_ready  out  1  issue accepted this cycle
flush  in  1  synchronous clear of all pending bits
pending_cnt  out  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset (async, rst=1): all registers 0, all pending bits 0; rd_data reflects zeros, rd_ready all 1, issue_ready 1, pending_cnt 0. Reset mid-operation discards all outstanding producers.
- Register 0: reads 0 always; writes ignored; never pending; issue to 0 accepted (issue_ready=1) with no effect.
- Read: rd_data[k] = regs[rd_addr[k]] combinationally, zero-latency; rd_ready[k] = !pending[rd_addr[k]], except the pending-cleared bypass case below.
- Write: if we && wr_addr!=0, regs[wr_addr] <= wr_data at clk edge. we without wr_clr is a plain write; it does not touch pending (used by single-cycle ALU ops).
- Scoreboard clear: we && wr_clr && wr_addr!=0 clears pending[wr_addr] at the edge. wr_clr without we is ignored.
- Issue: issue_ready = !pending[issue_addr] || (we && wr_clr && wr_addr==issue_addr). One outstanding producer per register; WAW to a pending register stalls.
- Issue handshake: issue_valid && issue_ready && issue_addr!=0 sets pending[issue_addr] at the edge.
- Simultaneous clear and issue to the same register: the set wins; pending remains 1 and the new data is written.
- flush: all pending bits 0 at the edge, overriding any same-cycle issue; register writes in that cycle still occur.
- pending_cnt: registered popcount, updated the same edge as the bits; range 0..NREGS-1.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: a write with we && wr_addr==rd_addr[k] && wr_addr!=0 forwards wr_data to rd_data[k] in the same cycle; if wr_clr is also set, rd_ready[k]=1.
- Undefined: reads return the pre-edge value; rd_ready[k] rises the cycle after the clearing write.

Decomposition:
- Shared package: DATA_W/NREGS defaults, the zero-register index constant, and the packed-port slice helper for the per-port index macro.
- Natural sub-module: rf_scoreboard, holding the pending bits, the issue/clear/flush logic, and pending_cnt. The parent keeps the storage array and the read muxes/bypass.

Test Plan:
- Reset: write r5=0x1234, assert rst mid-cycle -> rd_data of r5 = 0 immediately, rd_ready all 1, pending_cnt 0.
- Plain write/read: we=1, wr_addr=3, wr_data=0xDEADBEEF -> next cycle rd_data port1 (addr 3) = 0xDEADBEEF; write to r0 with 0xFFFF -> r0 still reads 0.
- Scoreboard: issue r7 -> rd_ready for r7 = 0, pending_cnt=1; second issue r7 -> issue_ready=0; we+wr_clr r7=0x55 -> next cycle rd_ready=1, data 0x55, pending_cnt=0.
- Simultaneous: r9 pending, same cycle we+wr_clr r9=0xAA and issue r9 -> r9=0xAA, pending[r9] stays 1, pending_cnt unchanged.
- Flush: pend r1, r2, r3 (pending_cnt=3), flush with issue r4 -> pending_cnt=0, r4 not pending.
- Bypass (RF_BYPASS_EN): rd_addr port0=6, same-cycle we+wr_clr r6=0x77 -> rd_data=0x77, rd_ready=1 that cycle; without the macro -> old value and rd_ready=0 that cycle.
